// File: rtl/wm8960_i2c_responder_pkg.sv
`default_nettype none
//============================================================================
// Package : wm8960_i2c_responder_pkg
// Brief   : Shared types and constants for the WM8960 control-port responder:
//           FSM state encoding, bus address, shadow size, soft-reset register.
// Rev     : 1.0  initial release
//============================================================================
package wm8960_i2c_responder_pkg;

    // Frame-level protocol states; *_ACK states cover the 9th SCL clock.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DEV    = 4'd1,
        ST_D_ACK  = 4'd2,
        ST_HI     = 4'd3,
        ST_H_ACK  = 4'd4,
        ST_LO     = 4'd5,
        ST_L_ACK  = 4'd6,
        ST_DONE   = 4'd7,
        ST_IGNORE = 4'd8
    } state_t;

    localparam logic [7:0] DEFAULT_DEV_ID    = 8'h34;
    localparam int         DEFAULT_REG_COUNT = 56;
    localparam logic [6:0] SOFT_RESET_REG    = 7'h0F;
    localparam int         FRAME_BYTES       = 3;

    // An abort is an error once the HI data byte has been acknowledged.
    function automatic logic abort_is_error(state_t s);
        return (s == ST_LO) || (s == ST_L_ACK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wm8960_i2c_responder_i2c_line_sync.sv
`default_nettype none
//============================================================================
// Module : wm8960_i2c_responder_i2c_line_sync (i2c_line_sync block)
// Brief  : Two-flop synchronizers on SCL/SDA, previous-value flops, and
//          registered SCL edge / START / STOP event pulses. Pin-to-event
//          latency is three clk cycles; sda_s is aligned with the events.
// Rev    : 1.0  initial release
//============================================================================
module wm8960_i2c_responder_i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Synchronize pins and register edge/condition events; reset to idle-high bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda_s    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
            scl_rise <= scl_sync[1] & ~scl_prev;
            scl_fall <= ~scl_sync[1] & scl_prev;
            start    <= scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
            stop     <= scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
            sda_s    <= sda_sync[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/wm8960_i2c_responder.sv
`default_nettype none
//============================================================================
// Module : wm8960_i2c_responder
// Brief  : I2C target emulating the WM8960 write-only control port. Decodes
//          {DEV_ID, HI, LO} frames into {7-bit reg, 9-bit value} writes,
//          ACKs them open-drain, and optionally shadows the register file.
// Config : WM8960_SHADOW_EN - build the REG_COUNT x 9 shadow register file
//          (soft-reset register 0x0F clears it); otherwise rd_data is 0.
// Rev    : 1.0  initial release
//============================================================================
module wm8960_i2c_responder
    import wm8960_i2c_responder_pkg::*;
#(
    parameter logic [7:0] DEV_ID    = DEFAULT_DEV_ID,
    parameter int         REG_COUNT = DEFAULT_REG_COUNT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic [7:0] wr_count,
    output logic       bus_error,
    input  logic [5:0] rd_addr,
    output logic [8:0] rd_data
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_s;

    wm8960_i2c_responder_i2c_line_sync u_i2c_line_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    state_t     state;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic [7:0] hi_byte;
    logic       ack_en;     // drive ACK (1) or NACK (0) in the current ACK slot
    logic       ack_phase;  // 0: waiting for fall to drive, 1: waiting for fall to release
    logic [7:0] byte_in;

    // Byte as it will look once the bit currently on sda_s is shifted in.
    assign byte_in = {shift[6:0], sda_s};

    // Frame length is implied by the HI/LO state sequence.
    logic unused_frame_bytes;
    assign unused_frame_bytes = FRAME_BYTES[0];

    // Protocol FSM: bit shifting, ACK driving, write reporting and error flagging.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            hi_byte   <= '0;
            ack_en    <= 1'b0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_count  <= '0;
            bus_error <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            if (start || stop) begin
                // START/STOP win over any coincident bit sample and drop the partial frame.
                if (abort_is_error(state)) begin
                    bus_error <= 1'b1;
                end
                state     <= start ? ST_DEV : ST_IDLE;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
            end else begin
                case (state)
                    ST_DEV, ST_HI, ST_LO: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ST_DEV) begin
                                    ack_en <= (byte_in == DEV_ID);
                                    state  <= ST_D_ACK;
                                end else if (state == ST_HI) begin
                                    hi_byte <= byte_in;
                                    ack_en  <= 1'b1;
                                    state   <= ST_H_ACK;
                                end else begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= hi_byte[7:1];
                                    wr_data  <= {hi_byte[0], byte_in};
                                    wr_count <= wr_count + 8'd1;
                                    ack_en   <= 1'b1;
                                    state    <= ST_L_ACK;
                                end
                            end
                        end
                    end
                    ST_D_ACK, ST_H_ACK, ST_L_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                ack_phase <= 1'b1;
                                sda_oe    <= ack_en;
                            end else begin
                                ack_phase <= 1'b0;
                                sda_oe    <= 1'b0;
                                bit_cnt   <= '0;
                                case (state)
                                    ST_D_ACK: state <= ack_en ? ST_HI : ST_IGNORE;
                                    ST_H_ACK: state <= ST_LO;
                                    default:  state <= ST_DONE;
                                endcase
                            end
                        end
                    end
                    ST_DONE: begin
                        // Bytes beyond the frame are NACKed (sda_oe stays low).
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                bus_error <= 1'b1;
                                state     <= ST_IGNORE;
                            end
                        end
                    end
                    default: begin
                        // IDLE and IGNORE wait for START/STOP only.
                        state <= state;
                    end
                endcase
            end
        end
    end

`ifdef WM8960_SHADOW_EN
    logic [8:0] shadow [REG_COUNT];

    // Shadow register file: commit on wr_valid, soft reset clears, registered read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                shadow[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_valid) begin
                if (wr_addr == SOFT_RESET_REG) begin
                    for (int i = 0; i < REG_COUNT; i++) begin
                        shadow[i] <= '0;
                    end
                end else if (int'(wr_addr) < REG_COUNT) begin
                    shadow[wr_addr[5:0]] <= wr_data;
                end
            end
            rd_data <= (int'(rd_addr) < REG_COUNT) ? shadow[rd_addr] : '0;
        end
    end
`else
    // No storage: reads always return zero.
    assign rd_data = '0;

    logic unused_shadow_cfg;
    assign unused_shadow_cfg = ^{rd_addr, SOFT_RESET_REG, REG_COUNT[0]};
`endif

endmodule
`default_nettype wire
